// File: rtl/exc_ctrl.sv
// MEM-stage exception/interrupt controller: prioritises events, commits CP0 state
// in a one-cycle COMMIT pulse, then holds a redirect until fetch accepts it.
module exc_ctrl #(
    parameter logic [31:0] EXC_VECTOR  = 32'hBFC00380,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  ext_int_i,
    input  logic [31:0] status_i,
    input  logic [31:0] cause_i,
    input  logic [31:0] epc_i,
    input  logic        inst_valid_i,
    input  logic        stall_i,
    input  logic [31:0] pc_i,
    input  logic        delayslot_i,
    input  logic [31:0] badvaddr_i,
    input  logic        adel_if_i,
    input  logic        ri_i,
    input  logic        ov_i,
    input  logic        sys_i,
    input  logic        bp_i,
    input  logic        adel_i,
    input  logic        ades_i,
    input  logic        eret_i,
    input  logic        redirect_ready_i,
    output logic        flush_o,
    output logic        busy_o,
    output logic        redirect_valid_o,
    output logic [31:0] redirect_pc_o,
    output logic        cp0_exc_we_o,
    output logic [4:0]  cp0_exccode_o,
    output logic        cp0_bd_o,
    output logic [31:0] cp0_epc_o,
    output logic        cp0_epc_we_o,
    output logic [31:0] cp0_badvaddr_o,
    output logic        cp0_badvaddr_we_o,
    output logic        cp0_eret_o
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] COMMIT   = 2'd1;
    localparam logic [1:0] REDIRECT = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [5:0]  sync_q [SYNC_STAGES];
    logic [4:0]  code_q, code_d;
    logic        is_eret_q, is_eret_d;
    logic        bd_q, bd_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] badvaddr_q, badvaddr_d;
    logic        badv_we_q, badv_we_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;

    logic [7:0]  ip;
    logic        int_pending;
    logic        any_event;
    logic        accept;
    logic        in_commit, in_redir, commit_exc;

    // Only the last synchronizer stage is considered metastability-safe.
    assign ip          = {sync_q[SYNC_STAGES-1], cause_i[9:8]};
    assign int_pending = status_i[0] & ~status_i[1] & (|(ip & status_i[15:8]));
    assign any_event   = int_pending | adel_if_i | ri_i | ov_i | sys_i | bp_i |
                         adel_i | ades_i | eret_i;
    assign accept      = (state_q == IDLE) & inst_valid_i & ~stall_i & any_event;

    always_comb begin
        // NOTE: every always_comb target gets a default first so no path can infer a latch.
        state_d       = state_q;
        code_d        = code_q;
        is_eret_d     = is_eret_q;
        bd_d          = bd_q;
        epc_d         = epc_q;
        badvaddr_d    = badvaddr_q;
        badv_we_d     = badv_we_q;
        redirect_pc_d = redirect_pc_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d    = COMMIT;
                    is_eret_d  = 1'b0;
                    badv_we_d  = 1'b0;
                    badvaddr_d = 32'd0;
                    bd_d       = delayslot_i;
                    epc_d      = delayslot_i ? pc_i - 32'd4 : pc_i;
                    if (int_pending)    code_d = 5'h00;
                    else if (adel_if_i) begin
                        code_d = 5'h04; badv_we_d = 1'b1; badvaddr_d = pc_i;
                    end
                    else if (ri_i)      code_d = 5'h0A;
                    else if (ov_i)      code_d = 5'h0C;
                    else if (sys_i)     code_d = 5'h08;
                    else if (bp_i)      code_d = 5'h09;
                    else if (adel_i) begin
                        code_d = 5'h04; badv_we_d = 1'b1; badvaddr_d = badvaddr_i;
                    end
                    else if (ades_i) begin
                        code_d = 5'h05; badv_we_d = 1'b1; badvaddr_d = badvaddr_i;
                    end
                    else begin
                        code_d = 5'h00; is_eret_d = 1'b1;
                    end
                end
            end
            COMMIT: begin
                state_d       = REDIRECT;
                redirect_pc_d = is_eret_q ? epc_i : EXC_VECTOR;
            end
            REDIRECT: begin
                if (redirect_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            state_q       <= IDLE;
            code_q        <= 5'd0;
            is_eret_q     <= 1'b0;
            bd_q          <= 1'b0;
            epc_q         <= 32'd0;
            badvaddr_q    <= 32'd0;
            badv_we_q     <= 1'b0;
            redirect_pc_q <= 32'd0;
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 6'd0;
        end else begin
            state_q       <= state_d;
            code_q        <= code_d;
            is_eret_q     <= is_eret_d;
            bd_q          <= bd_d;
            epc_q         <= epc_d;
            badvaddr_q    <= badvaddr_d;
            badv_we_q     <= badv_we_d;
            redirect_pc_q <= redirect_pc_d;
            sync_q[0]     <= ext_int_i;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign in_commit  = (state_q == COMMIT);
    assign in_redir   = (state_q == REDIRECT);
    assign commit_exc = in_commit & ~is_eret_q;

    // Data outputs are gated so they read as zero whenever no commit is in progress.
    assign flush_o           = in_commit | in_redir;
    assign busy_o            = (state_q != IDLE);
    assign redirect_valid_o  = in_redir;
    assign redirect_pc_o     = in_redir ? redirect_pc_q : 32'd0;
    assign cp0_exc_we_o      = commit_exc;
    assign cp0_exccode_o     = commit_exc ? code_q : 5'd0;
    assign cp0_bd_o          = commit_exc & bd_q;
    assign cp0_epc_o         = commit_exc ? epc_q : 32'd0;
    assign cp0_epc_we_o      = commit_exc & ~status_i[1];
    assign cp0_badvaddr_o    = (commit_exc & badv_we_q) ? badvaddr_q : 32'd0;
    assign cp0_badvaddr_we_o = commit_exc & badv_we_q;
    assign cp0_eret_o        = in_commit & is_eret_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed bench for exc_ctrl: a vector table for single events plus hand-written
// sequences for stalls, interrupt synchronisation, redirect back-pressure and reset abort.
module tb_exc_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  ext_int_i;
    logic [31:0] status_i, cause_i, epc_i, pc_i, badvaddr_i;
    logic        inst_valid_i, stall_i, delayslot_i;
    logic        adel_if_i, ri_i, ov_i, sys_i, bp_i, adel_i, ades_i, eret_i;
    logic        redirect_ready_i;
    logic        flush_o, busy_o, redirect_valid_o;
    logic [31:0] redirect_pc_o;
    logic        cp0_exc_we_o;
    logic [4:0]  cp0_exccode_o;
    logic        cp0_bd_o;
    logic [31:0] cp0_epc_o;
    logic        cp0_epc_we_o;
    logic [31:0] cp0_badvaddr_o;
    logic        cp0_badvaddr_we_o;
    logic        cp0_eret_o;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    exc_ctrl dut (
        .clk(clk), .rst(rst), .ext_int_i(ext_int_i), .status_i(status_i),
        .cause_i(cause_i), .epc_i(epc_i), .inst_valid_i(inst_valid_i),
        .stall_i(stall_i), .pc_i(pc_i), .delayslot_i(delayslot_i),
        .badvaddr_i(badvaddr_i), .adel_if_i(adel_if_i), .ri_i(ri_i), .ov_i(ov_i),
        .sys_i(sys_i), .bp_i(bp_i), .adel_i(adel_i), .ades_i(ades_i),
        .eret_i(eret_i), .redirect_ready_i(redirect_ready_i), .flush_o(flush_o),
        .busy_o(busy_o), .redirect_valid_o(redirect_valid_o),
        .redirect_pc_o(redirect_pc_o), .cp0_exc_we_o(cp0_exc_we_o),
        .cp0_exccode_o(cp0_exccode_o), .cp0_bd_o(cp0_bd_o), .cp0_epc_o(cp0_epc_o),
        .cp0_epc_we_o(cp0_epc_we_o), .cp0_badvaddr_o(cp0_badvaddr_o),
        .cp0_badvaddr_we_o(cp0_badvaddr_we_o), .cp0_eret_o(cp0_eret_o)
    );

    // flags = {adel_if, ri, ov, sys, bp, adel, ades, eret}
    typedef struct {
        string       name;
        logic [7:0]  flags;
        logic [31:0] pc;
        logic        ds;
        logic [31:0] badv;
        logic [31:0] status;
        logic [31:0] epc_in;
        logic [4:0]  exp_code;
        logic        exp_exc_we;
        logic        exp_bd;
        logic [31:0] exp_epc;
        logic        exp_epc_we;
        logic        exp_badv_we;
        logic [31:0] exp_badv;
        logic        exp_eret;
        logic [31:0] exp_rpc;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic set_flags(input logic [7:0] f);
        {adel_if_i, ri_i, ov_i, sys_i, bp_i, adel_i, ades_i, eret_i} = f;
    endtask

    function automatic logic [31:0] all_outs();
        return {flush_o, busy_o, redirect_valid_o, cp0_exc_we_o, cp0_bd_o,
                cp0_epc_we_o, cp0_badvaddr_we_o, cp0_eret_o}
               | {24'd0, cp0_exccode_o, 3'd0}
               | redirect_pc_o | cp0_epc_o | cp0_badvaddr_o;
    endfunction

    // Offer one event in IDLE; on return the DUT has just entered COMMIT (sampled at negedge).
    task automatic launch(input logic [7:0] f, input logic [31:0] pc, input logic ds,
                          input logic [31:0] badv, input logic [31:0] st, input logic [31:0] epc);
        set_flags(f);
        pc_i = pc; delayslot_i = ds; badvaddr_i = badv; status_i = st; epc_i = epc;
        inst_valid_i = 1'b1;
        @(negedge clk);
        set_flags(8'd0);
        inst_valid_i = 1'b0;
    endtask

    initial begin
        vecs[0] = '{"sys",        8'b0001_0000, 32'h80001000, 1'b0, 32'h0, 32'h0040FF00, 32'h0,
                    5'h08, 1'b1, 1'b0, 32'h80001000, 1'b1, 1'b0, 32'h0, 1'b0, 32'hBFC00380};
        vecs[1] = '{"ov_bp_ds",   8'b0010_1000, 32'h80002004, 1'b1, 32'h0, 32'h0040FF00, 32'h0,
                    5'h0C, 1'b1, 1'b1, 32'h80002000, 1'b1, 1'b0, 32'h0, 1'b0, 32'hBFC00380};
        vecs[2] = '{"ades_exl",   8'b0000_0010, 32'h80004000, 1'b0, 32'h00000003, 32'h00000002, 32'h0,
                    5'h05, 1'b1, 1'b0, 32'h80004000, 1'b0, 1'b1, 32'h00000003, 1'b0, 32'hBFC00380};
        vecs[3] = '{"adelif_ri",  8'b1100_0000, 32'h00001001, 1'b0, 32'h5555AAAA, 32'h0, 32'h0,
                    5'h04, 1'b1, 1'b0, 32'h00001001, 1'b1, 1'b1, 32'h00001001, 1'b0, 32'hBFC00380};
        vecs[4] = '{"eret",       8'b0000_0001, 32'h80005000, 1'b0, 32'h0, 32'h0, 32'h80003000,
                    5'h00, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h80003000};
        vecs[5] = '{"sys_eret",   8'b0001_0001, 32'h80006000, 1'b0, 32'h0, 32'h0, 32'h80003000,
                    5'h08, 1'b1, 1'b0, 32'h80006000, 1'b1, 1'b0, 32'h0, 1'b0, 32'hBFC00380};
        vecs[6] = '{"bp_adel",    8'b0000_1100, 32'h80007000, 1'b0, 32'h00000011, 32'h0, 32'h0,
                    5'h09, 1'b1, 1'b0, 32'h80007000, 1'b1, 1'b0, 32'h0, 1'b0, 32'hBFC00380};
        vecs[7] = '{"ri_wrap",    8'b0100_0000, 32'h00000000, 1'b1, 32'h0, 32'h0, 32'h0,
                    5'h0A, 1'b1, 1'b1, 32'hFFFFFFFC, 1'b1, 1'b0, 32'h0, 1'b0, 32'hBFC00380};
        vecs[8] = '{"adel_data",  8'b0000_0100, 32'h80008000, 1'b0, 32'h00001235, 32'h0, 32'h0,
                    5'h04, 1'b1, 1'b0, 32'h80008000, 1'b1, 1'b1, 32'h00001235, 1'b0, 32'hBFC00380};

        rst = 1'b1; ext_int_i = 6'd0; status_i = 32'd0; cause_i = 32'd0; epc_i = 32'd0;
        pc_i = 32'd0; badvaddr_i = 32'd0; inst_valid_i = 1'b0; stall_i = 1'b0;
        delayslot_i = 1'b0; redirect_ready_i = 1'b1; set_flags(8'd0);
        repeat (3) @(negedge clk);
        check("reset_outputs", all_outs(), 32'd0);
        rst = 1'b0;

        // Table-driven single events, ready asserted so the redirect completes at once.
        foreach (vecs[i]) begin
            launch(vecs[i].flags, vecs[i].pc, vecs[i].ds, vecs[i].badv, vecs[i].status,
                   vecs[i].epc_in);
            check({vecs[i].name, "_flush"},   {31'd0, flush_o},           32'd1);
            check({vecs[i].name, "_exc_we"},  {31'd0, cp0_exc_we_o},      {31'd0, vecs[i].exp_exc_we});
            check({vecs[i].name, "_code"},    {27'd0, cp0_exccode_o},     {27'd0, vecs[i].exp_code});
            check({vecs[i].name, "_bd"},      {31'd0, cp0_bd_o},          {31'd0, vecs[i].exp_bd});
            check({vecs[i].name, "_epc"},     cp0_epc_o,                  vecs[i].exp_epc);
            check({vecs[i].name, "_epc_we"},  {31'd0, cp0_epc_we_o},      {31'd0, vecs[i].exp_epc_we});
            check({vecs[i].name, "_badv_we"}, {31'd0, cp0_badvaddr_we_o}, {31'd0, vecs[i].exp_badv_we});
            check({vecs[i].name, "_badv"},    cp0_badvaddr_o,             vecs[i].exp_badv);
            check({vecs[i].name, "_eret"},    {31'd0, cp0_eret_o},        {31'd0, vecs[i].exp_eret});
            @(negedge clk);
            check({vecs[i].name, "_rvalid"},  {31'd0, redirect_valid_o},  32'd1);
            check({vecs[i].name, "_rpc"},     redirect_pc_o,              vecs[i].exp_rpc);
            check({vecs[i].name, "_pulses_redir"},
                  {29'd0, cp0_exc_we_o, cp0_epc_we_o | cp0_badvaddr_we_o, cp0_eret_o}, 32'd0);
            @(negedge clk);
            check({vecs[i].name, "_idle"},    all_outs(),                 32'd0);
        end

        // Stalled or invalid instructions must not start a sequence.
        stall_i = 1'b1;
        launch(8'b0001_0000, 32'h80009000, 1'b0, 32'h0, 32'h0, 32'h0);
        check("stall_ignored", {31'd0, busy_o}, 32'd0);
        stall_i = 1'b0;
        set_flags(8'b0001_0000); inst_valid_i = 1'b0;
        @(negedge clk);
        check("invalid_ignored", {31'd0, busy_o}, 32'd0);
        set_flags(8'd0);

        // Interrupt: ext_int_i[2] -> IP4, enabled by IM4; COMMIT after SYNC_STAGES+1 edges.
        status_i = 32'h0000FF01; pc_i = 32'h8000A000; delayslot_i = 1'b0;
        inst_valid_i = 1'b1; ext_int_i = 6'b000100;
        @(negedge clk);
        check("int_sync1", {31'd0, busy_o}, 32'd0);
        @(negedge clk);
        check("int_sync2", {31'd0, busy_o}, 32'd0);
        @(negedge clk);
        inst_valid_i = 1'b0; ext_int_i = 6'd0;
        check("int_commit_we", {31'd0, cp0_exc_we_o}, 32'd1);
        check("int_code", {27'd0, cp0_exccode_o}, 32'h00);
        check("int_epc", cp0_epc_o, 32'h8000A000);
        @(negedge clk);
        check("int_rpc", redirect_pc_o, 32'hBFC00380);
        repeat (3) @(negedge clk);
        check("int_done", {31'd0, busy_o}, 32'd0);

        // Same interrupt with EXL set is masked.
        status_i = 32'h0000FF03; inst_valid_i = 1'b1; ext_int_i = 6'b000100;
        repeat (5) begin
            @(negedge clk);
            check("int_exl_masked", {31'd0, busy_o}, 32'd0);
        end
        ext_int_i = 6'd0; inst_valid_i = 1'b0;
        repeat (3) @(negedge clk);

        // ERET with fetch back-pressure: redirect must hold steady.
        redirect_ready_i = 1'b0;
        launch(8'b0000_0001, 32'h8000B000, 1'b0, 32'h0, 32'h0, 32'h80003000);
        check("eret_pulse", {31'd0, cp0_eret_o}, 32'd1);
        check("eret_no_exc_we", {31'd0, cp0_exc_we_o}, 32'd0);
        @(negedge clk);
        epc_i = 32'hDEAD0000;
        repeat (3) begin
            check("eret_hold_valid", {31'd0, redirect_valid_o}, 32'd1);
            check("eret_hold_pc", redirect_pc_o, 32'h80003000);
            check("eret_hold_flush", {31'd0, flush_o}, 32'd1);
            check("eret_hold_nopulse", {31'd0, cp0_eret_o}, 32'd0);
            @(negedge clk);
        end
        redirect_ready_i = 1'b1;
        @(negedge clk);
        check("eret_released", all_outs(), 32'd0);

        // Reset while waiting in REDIRECT aborts the sequence.
        redirect_ready_i = 1'b0;
        launch(8'b0000_0010, 32'h8000C000, 1'b0, 32'h00000003, 32'h00000002, 32'h0);
        check("ades_code", {27'd0, cp0_exccode_o}, 32'h05);
        @(negedge clk);
        check("ades_in_redirect", {31'd0, redirect_valid_o}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_abort_outputs", all_outs(), 32'd0);
        rst = 1'b0; redirect_ready_i = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_abort_stays_idle", all_outs(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
